// File: rtl/fetch_sequencer_if.sv
// Bundle of IF-stage control inputs, instruction-memory port and IF/ID outputs.
// The slave modport is the fetch sequencer; the master modport is whoever drives it.
interface fetch_sequencer_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_instr;
  logic [31:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;

  modport slave (
    input  stall, flush, branch_taken, branch_target, jump, jump_target, imem_instr,
    output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, halted
  );

  modport master (
    output stall, flush, branch_taken, branch_target, jump, jump_target, imem_instr,
    input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: owns the PC, addresses the combinational instruction memory
// and fills the IF/ID register, handling stall, flush, redirects and halt.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input logic              clk,
  input logic              rst_n,
  fetch_sequencer_if.slave bus
);

  localparam logic [31:0] PC_SPAN = 32'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        halt_hit;

  // Jump outranks a taken branch; targets are forced word-aligned.
  assign redirect = bus.jump | bus.branch_taken;
  assign target   = (bus.jump ? bus.jump_target : bus.branch_target) & ~32'h3;
  assign pc_inc   = pc_q + 32'd4;
  assign pc_plus4 = (pc_inc >= PC_SPAN) ? 32'd0 : pc_inc;
  assign advance  = !redirect && !bus.stall && !bus.flush;
  assign halt_hit = (bus.imem_instr == HALT_WORD);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: every signal written here gets a hold default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_d    = target;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (bus.flush && !bus.stall) begin
          pc_d    = pc_plus4;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          instr_d = bus.imem_instr;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          if (advance && halt_hit) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      HALTED: begin
        instr_d = '0;
        valid_d = 1'b0;
        if (redirect) begin
          pc_d    = target;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    bus.imem_addr      = pc_q;
    bus.if_id_instr    = instr_q;
    bus.if_id_pc_plus4 = pc4_q;
    bus.if_id_valid    = valid_q;
    bus.halted         = (state_q == HALTED);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for the main flow plus
// hand sequences for halt, BOOT redirect suppression and asynchronous reset.
module tb_fetch_sequencer;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [31:0] jmp_tgt;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [31:0] mem [0:1023];
  int checks;
  int errors;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(1024),
    .HALT_WORD (HALT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always_comb bus.imem_instr = mem[10'(bus.imem_addr >> 2)];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " addr"},   bus.imem_addr,           v.addr);
    check({tag, " instr"},  bus.if_id_instr,         v.instr);
    check({tag, " pc4"},    bus.if_id_pc_plus4,      v.pc4);
    check({tag, " valid"},  32'(bus.if_id_valid),    32'(v.valid));
    check({tag, " halted"}, 32'(bus.halted),         32'(v.halted));
  endtask

  // Drive inputs, take one rising edge, then compare 1 ns later.
  task automatic apply_vec(input string tag, input vec_t v);
    bus.stall         = v.stall;
    bus.flush         = v.flush;
    bus.branch_taken  = v.br;
    bus.branch_target = v.br_tgt;
    bus.jump          = v.jmp;
    bus.jump_target   = v.jmp_tgt;
    @(posedge clk);
    #1;
    check_outputs(tag, v);
  endtask

  function automatic vec_t idle(input logic [31:0] addr, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic valid, input logic halted);
    vec_t v;
    v = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, addr, instr, pc4, valid, halted};
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h44;

    //           stall flush br  br_tgt       jmp jmp_tgt      addr         instr          pc4          v  h
    vecs[0]  = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h000, 32'h0,         32'h000, 0, 0}; // BOOT edge
    vecs[1]  = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h004, 32'h11,        32'h004, 1, 0};
    vecs[2]  = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h008, 32'h22,        32'h008, 1, 0};
    vecs[3]  = '{1, 0, 0, 32'h0,   0, 32'h0,   32'h008, 32'h22,        32'h008, 1, 0};
    vecs[4]  = '{1, 0, 0, 32'h0,   0, 32'h0,   32'h008, 32'h22,        32'h008, 1, 0};
    vecs[5]  = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h00C, 32'h33,        32'h00C, 1, 0};
    vecs[6]  = '{1, 0, 1, 32'h102, 0, 32'h0,   32'h100, 32'h0,         32'h00C, 0, 0};
    vecs[7]  = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h104, 32'h1000_0040, 32'h104, 1, 0};
    vecs[8]  = '{0, 1, 0, 32'h0,   0, 32'h0,   32'h108, 32'h0,         32'h104, 0, 0};
    vecs[9]  = '{1, 1, 0, 32'h0,   0, 32'h0,   32'h108, 32'h0,         32'h104, 0, 0};
    vecs[10] = '{0, 0, 1, 32'h80,  1, 32'h40,  32'h040, 32'h0,         32'h104, 0, 0};
    vecs[11] = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h044, 32'h1000_0010, 32'h044, 1, 0};
    vecs[12] = '{0, 0, 0, 32'h0,   1, 32'hFFC, 32'hFFC, 32'h0,         32'h044, 0, 0};
    vecs[13] = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h000, 32'h1000_03FF, 32'h000, 1, 0};
    vecs[14] = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h004, 32'h11,        32'h004, 1, 0};

    bus.stall = 0; bus.flush = 0; bus.branch_taken = 0; bus.jump = 0;
    bus.branch_target = '0; bus.jump_target = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", idle(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) apply_vec($sformatf("v%0d", i), vecs[i]);

    // Halt sequence: word 2 becomes the halt encoding.
    mem[2] = HALT;
    apply_vec("h_jmp0", '{0, 0, 0, 32'h0, 1, 32'h0, 32'h000, 32'h0, 32'h004, 0, 0});
    apply_vec("h_w0",   idle(32'h004, 32'h11, 32'h004, 1, 0));
    apply_vec("h_w1",   idle(32'h008, 32'h22, 32'h008, 1, 0));
    apply_vec("h_hit",  idle(32'h008, HALT,   32'h00C, 1, 1));
    apply_vec("h_drop", '{1, 1, 0, 32'h0, 0, 32'h0, 32'h008, 32'h0, 32'h00C, 0, 1});
    apply_vec("h_stay", idle(32'h008, 32'h0, 32'h00C, 0, 1));
    apply_vec("h_exit", '{0, 0, 0, 32'h0, 1, 32'h0, 32'h000, 32'h0, 32'h00C, 0, 0});
    apply_vec("h_res0", idle(32'h004, 32'h11, 32'h004, 1, 0));
    apply_vec("h_res1", idle(32'h008, 32'h22, 32'h008, 1, 0));
    apply_vec("h_hit2", idle(32'h008, HALT,   32'h00C, 1, 1));

    // Asynchronous reset mid-HALTED, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", idle(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));

    // Redirect during BOOT must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec("boot_jmp", '{0, 0, 1, 32'h80, 1, 32'h40, 32'h000, 32'h0, 32'h000, 0, 0});
    apply_vec("boot_run", idle(32'h004, 32'h11, 32'h004, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences the word-addressed instruction memory for the IF stage: drives the fetch address, latches the returned instruction into the IF/ID pipeline register and tracks a valid bit.
- Handles stall, flush, branch and jump redirects, and a halt condition.
- The instruction memory is combinational-read (word index = address/4). This block supplies its address and registers its output; the memory itself is unchanged.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; PC wraps modulo IMEM_WORDS*4.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Stall  in  1  hazard stall from ID: hold PC and IF/ID contents.
- Flush  in  1  squash the instruction currently in IF/ID.
- BranchTaken  in  1  branch resolved taken.
- BranchTarget  in  32  branch target byte address.
- Jump  in  1  jump redirect.
- JumpTarget  in  32  jump target byte address.
- ImemInstr  in  32  combinational instruction returned for ImemAddr.
- ImemAddr  out  32  byte fetch address to instruction memory (= PC).
- IfIdInstr  out  32  registered instruction.
- IfIdPCPlus4  out  32  registered PC+4 of that instruction.
- IfIdValid  out  1  IF/ID holds a live instruction.
- Halted  out  1  fetch is halted.

Behaviour:
- Reset (async, Rst_n=0):
  - PC=RESET_PC, state=BOOT.
  - IfIdInstr=0, IfIdPCPlus4=0, IfIdValid=0, Halted=0.
  - ImemAddr follows PC combinationally, so it equals RESET_PC during reset.
- Targets have bits[1:0] forced to 0 before use. All PC arithmetic is mod IMEM_WORDS*4: (IMEM_WORDS*4-4)+4 wraps to 0.
- Redirect = Jump | BranchTaken.
  - Jump has priority over BranchTaken when both are asserted.
  - A redirect overrides Stall.
- States:
  - BOOT: one cycle after reset release. IfIdValid stays 0, PC unchanged. Next state is RUN. Redirect inputs are ignored in BOOT.
  - RUN, per rising edge, in priority order:
    - Redirect: PC<=target, IfIdValid<=0, IfIdInstr<=0. This also squashes the wrong-path fetch.
    - Else Flush & !Stall: PC<=PC+4, IfIdInstr<=0, IfIdValid<=0.
    - Else Stall: PC, IfIdInstr, IfIdPCPlus4 and IfIdValid all hold. Flush during Stall is ignored.
    - Else: PC<=PC+4, IfIdInstr<=ImemInstr, IfIdPCPlus4<=PC+4, IfIdValid<=1.
    - If the word being latched in the normal-advance case equals HALT_WORD: it is latched with IfIdValid<=1, PC holds (does not advance), and the state moves to HALTED.
  - HALTED:
    - Halted=1. PC holds.
    - On the next edge IfIdInstr<=0 and IfIdValid<=0, and both stay 0.
    - A redirect (Jump/BranchTaken) returns to RUN with PC<=target and Halted<=0, because an older control transfer cancels a speculative halt.
    - Stall and Flush are ignored.
- Latency: the instruction at PC appears on IfIdInstr one edge after PC is presented. Redirect-to-first-valid takes 2 edges.
- Reset asserted mid-operation wins immediately, in any state.

Test Plan:
- Reset then free-run with memory words 0..3 = 0x11,0x22,0x33,0x44 -> IfIdValid=0 during BOOT; then IfIdInstr=0x11,0x22,0x33 on successive edges; IfIdPCPlus4=4,8,12; ImemAddr=0,4,8,12.
- Stall high 2 cycles while IfIdInstr=0x22 -> PC holds at 8 and IfIdInstr stays 0x22 for both cycles; resumes with 0x33.
- BranchTaken=1, BranchTarget=0x102 with Stall=1 on the same edge -> PC=0x100, IfIdValid=0; next edge latches word 64.
- Jump=1 (target 0x40) and BranchTaken=1 (target 0x80) together -> PC=0x40.
- PC=IMEM_WORDS*4-4 (0xFFC) with no redirect -> next PC=0x000.
- Memory word 2 = 0xFFFFFFFF -> it is latched with IfIdValid=1, Halted=1 after it, PC holds at 8, IfIdValid drops to 0 next edge; then Jump to 0x0 -> Halted=0 and fetch resumes at 0.
- Assert Rst_n=0 asynchronously mid-HALTED -> all outputs return to reset values without waiting for a clock edge.
